ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
// Sends one command byte to a keyboard. The sequence is: clock inhibit,
// request-to-send, ten device-clocked bits (8 data bits LSB first, odd
// parity, stop), then the device ACK and a wait for the bus to go idle.
// Ports:
//   clk, resetN            - clock, synchronous active-high reset
//   tx_data, tx_valid      - command byte and send request
//   tx_ready               - high while idle; a request is accepted then
//   PS2C, PS2D             - raw (asynchronous) PS/2 line levels
//   ps2c_oe, ps2d_oe       - 1 = pull the line low (open collector)
//   tx_done, tx_error      - single-cycle completion / failure pulses
module ps2_host_tx #(
    parameter int unsigned CLK_HOLD_CYCLES = 5000,
    parameter int unsigned REQ_CYCLES      = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 750000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned MAX_HR  = (CLK_HOLD_CYCLES > REQ_CYCLES) ? CLK_HOLD_CYCLES : REQ_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_HR > TIMEOUT_CYCLES) ? MAX_HR : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned BIT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BIT_W-1:0]   bit_idx, bit_n;
    logic [9:0]         frame, frame_n;
    logic               c_oe_n, d_oe_n, done_n, err_n, ready_n;
    logic               c_meta, c_sync, c_prev;
    logic               d_meta, d_sync;
    logic               fall;
    logic               timeout_hit;

    // Device clock falling edge, seen on the synchronized line.
    assign fall        = c_prev & ~c_sync;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Registers: synchronizers, state, counters and all outputs.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            frame    <= '0;
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            tx_ready <= 1'b1;
            c_meta   <= 1'b1;
            c_sync   <= 1'b1;
            c_prev   <= 1'b1;
            d_meta   <= 1'b1;
            d_sync   <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            frame    <= frame_n;
            ps2c_oe  <= c_oe_n;
            ps2d_oe  <= d_oe_n;
            tx_done  <= done_n;
            tx_error <= err_n;
            tx_ready <= ready_n;
            c_meta   <= PS2C;
            c_sync   <= c_meta;
            c_prev   <= c_sync;
            d_meta   <= PS2D;
            d_sync   <= d_meta;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        frame_n = frame;
        c_oe_n  = ps2c_oe;
        d_oe_n  = ps2d_oe;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    // Frame bits in send order: data LSB first, odd parity, stop.
                    frame_n = {1'b1, ~^tx_data, tx_data};
                    state_n = INHIBIT;
                    cnt_n   = '0;
                    c_oe_n  = 1'b1;
                    d_oe_n  = 1'b0;
                end
            end
            INHIBIT: begin
                if (cnt == CNT_W'(CLK_HOLD_CYCLES - 1)) begin
                    state_n = REQ;
                    cnt_n   = '0;
                    d_oe_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            REQ: begin
                if (cnt == CNT_W'(REQ_CYCLES - 1)) begin
                    // Release the clock; data stays low as the start bit.
                    state_n = BITS;
                    cnt_n   = '0;
                    bit_n   = '0;
                    c_oe_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            BITS: begin
                if (fall) begin
                    cnt_n  = '0;
                    d_oe_n = ~frame[bit_idx];
                    bit_n  = bit_idx + BIT_W'(1);
                    if (bit_idx == BIT_W'(9)) begin
                        state_n = ACK;
                    end
                end else if (timeout_hit) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    c_oe_n  = 1'b0;
                    d_oe_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ACK: begin
                if (fall) begin
                    cnt_n = '0;
                    if (!d_sync) begin
                        state_n = WAIT_IDLE;
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    c_oe_n  = 1'b0;
                    d_oe_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (c_sync && d_sync) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else if (timeout_hit) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    c_oe_n  = 1'b0;
                    d_oe_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                c_oe_n  = 1'b0;
                d_oe_n  = 1'b0;
            end
        endcase

        ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with an open-collector
// PS/2 device model and a frame-level reference model.
module tb_ps2_host_tx;

    localparam int unsigned HOLD = 20;
    localparam int unsigned REQC = 16;
    localparam int unsigned TMO  = 100;

    logic       clk = 1'b0;
    logic       resetN;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2c_oe, ps2d_oe, tx_done, tx_error;
    logic       dev_c_low, dev_d_low;
    logic       ps2c_line, ps2d_line;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    int err_seen  = 0;
    int both_seen = 0;

    always #5 clk = ~clk;

    // Wired-AND bus: either side can pull a line low.
    assign ps2c_line = ~(ps2c_oe | dev_c_low);
    assign ps2d_line = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(
        .CLK_HOLD_CYCLES(HOLD),
        .REQ_CYCLES     (REQC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .resetN  (resetN),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .PS2C    (ps2c_line),
        .PS2D    (ps2d_line),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .tx_done (tx_done),
        .tx_error(tx_error)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_done)              done_seen++;
        if (tx_error)             err_seen++;
        if (tx_done && tx_error)  both_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line levels in send order: 8 data bits LSB first, odd parity, stop.
    function automatic logic [9:0] exp_levels(input logic [7:0] d);
        int ones = 0;
        logic [9:0] r;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        r[7:0] = d;
        r[8]   = ((ones % 2) == 0);
        r[9]   = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        resetN    = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        cyc(3);
        resetN = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
        check_eq("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    endtask

    // One host transmission with the device model answering.
    // reset_after: apply reset after that device falling edge (0 = never).
    task automatic send_frame(input logic [7:0] d, input bit ack_ok, input bit hold_valid,
                              input int reset_after, input bit no_clock,
                              output logic [9:0] got);
        int n;
        int d0 = done_seen;
        int e0 = err_seen;
        logic [3:0] idx;
        got = '0;

        n = 0;
        while (!tx_ready && n < 200) begin @(negedge clk); n++; end
        check_eq("ready_before", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        if (!hold_valid) tx_valid = 1'b0;
        else             tx_data  = ~d;
        check_eq("ready_busy", 32'(tx_ready), 32'd0);

        n = 0;
        while (ps2c_oe && !ps2d_oe && n < int'(HOLD) + 10) begin n++; @(negedge clk); end
        check_eq("inhibit_len", 32'(n), 32'(HOLD));
        n = 0;
        while (ps2c_oe && ps2d_oe && n < int'(REQC) + 10) begin n++; @(negedge clk); end
        check_eq("req_len", 32'(n), 32'(REQC));
        check_eq("start_bit", 32'({ps2c_oe, ps2d_oe}), 32'b01);

        if (no_clock) begin
            n = 0;
            while (!tx_error && n < int'(TMO) + 20) begin @(negedge clk); n++; end
            check_eq("timeout_lat", 32'(n), 32'(TMO));
            check_eq("timeout_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
            @(negedge clk);
            check_eq("timeout_ready", 32'(tx_ready), 32'd1);
            check_eq("timeout_done", 32'(done_seen - d0), 32'd0);
            return;
        end

        for (int k = 1; k <= 11; k++) begin
            cyc($urandom_range(6, 12));
            if (k == 11) begin
                dev_d_low = ack_ok;
                cyc(4);
            end
            dev_c_low = 1'b1;
            if (k == 11 && !ack_ok) begin
                n = 0;
                while (!tx_error && n < 20) begin @(negedge clk); n++; end
                check_eq("nack_err", 32'(tx_error), 32'd1);
                @(negedge clk);
                check_eq("nack_ready", 32'(tx_ready), 32'd1);
                cyc(4);
            end else begin
                cyc($urandom_range(6, 12));
            end
            if (k <= 10) begin
                idx = 4'(k - 1);
                got[idx] = ps2d_line;
            end
            if (k == reset_after) begin
                resetN = 1'b1;
                @(negedge clk);
                resetN = 1'b0;
                check_eq("midrst_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
                check_eq("midrst_ready", 32'(tx_ready), 32'd1);
                dev_c_low = 1'b0;
                cyc(10);
                check_eq("midrst_pulses", 32'((done_seen - d0) + (err_seen - e0)), 32'd0);
                return;
            end
            dev_c_low = 1'b0;
        end

        if (ack_ok) begin
            cyc($urandom_range(2, 6));
            dev_d_low = 1'b0;
            n = 0;
            while (!tx_done && n < 40) begin @(negedge clk); n++; end
            check_eq("done_seen", 32'(tx_done), 32'd1);
            check_eq("idle_at_done", 32'({ps2c_line, ps2d_line}), 32'b11);
            tx_valid = 1'b0;
            cyc(3);
            check_eq("done_count", 32'(done_seen - d0), 32'd1);
            check_eq("done_noerr", 32'(err_seen - e0), 32'd0);
            check_eq("idle_ready", 32'(tx_ready), 32'd1);
        end else begin
            dev_d_low = 1'b0;
            cyc(3);
            check_eq("nack_count", 32'(err_seen - e0), 32'd1);
            check_eq("nack_nodone", 32'(done_seen - d0), 32'd0);
        end
    endtask

    initial begin
        logic [9:0] got;
        logic [7:0] d;
        bit ok;

        do_reset();

        send_frame(8'hED, 1'b1, 1'b0, 0, 1'b0, got);
        check_eq("ed_levels", 32'(got), 32'b11_1110_1101);

        send_frame(8'hF4, 1'b1, 1'b0, 0, 1'b0, got);
        check_eq("f4_parity", 32'(got[8]), 32'd0);
        check_eq("f4_levels", 32'(got), 32'(exp_levels(8'hF4)));

        send_frame(8'hFF, 1'b1, 1'b0, 0, 1'b0, got);
        check_eq("ff_parity", 32'(got[8]), 32'd1);

        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok, 1'b0, 0, 1'b0, got);
            check_eq("rand_levels", 32'(got), 32'(exp_levels(d)));
        end

        send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b0, got);
        check_eq("nack_levels", 32'(got), 32'(exp_levels(8'h5A)));

        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b1, 0, 1'b0, got);
        check_eq("hold_levels", 32'(got), 32'(exp_levels(d)));

        send_frame(8'h3C, 1'b1, 1'b0, 5, 1'b0, got);

        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b1, got);

        send_frame(8'h81, 1'b1, 1'b0, 0, 1'b0, got);
        check_eq("post_levels", 32'(got), 32'(exp_levels(8'h81)));

        check_eq("never_both", 32'(both_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
